product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 113 +++++++++++
 tb/tb_product_accumulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums a job of len unsigned products into acc_out; result is registered 1 cycle after the last product.
// Result is held in DONE until out_ready; products and start arriving outside their accepting state are dropped.
module product_accumulator #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12,
    parameter int LEN_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   len,
    input  logic                   p_valid,
    input  logic [2*WIDTH-1:0]     p,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state;
    state_t                next_state;
    logic [LEN_WIDTH-1:0]  count;
    logic [LEN_WIDTH-1:0]  count_next;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic                  ovf_next;
    logic                  out_valid_next;
    logic                  busy_next;
    logic [ACC_WIDTH:0]    p_ext;
    logic [ACC_WIDTH:0]    sum;

    // One extra bit on the adder captures the carry that drives the sticky overflow.
    assign p_ext = {{(ACC_WIDTH+1-2*WIDTH){1'b0}}, p};
    assign sum   = {1'b0, acc_out} + p_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            out_valid <= out_valid_next;
            busy      <= busy_next;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (p_valid && count == LEN_WIDTH'(1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Status flags are derived from the upcoming state so they leave the flops glitch-free.
    always_comb begin
        out_valid_next = (next_state == DONE);
        busy_next      = (next_state != IDLE);
    end

    always_comb begin
        acc_next   = acc_out;
        ovf_next   = overflow;
        count_next = count;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    count_next = len;
                end
            end
            ACCUM: begin
                if (p_valid) begin
                    acc_next   = sum[ACC_WIDTH-1:0];
                    ovf_next   = overflow | sum[ACC_WIDTH];
                    count_next = count - LEN_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            acc_out  <= acc_next;
            overflow <= ovf_next;
            count    <= count_next;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed jobs; a queue-based scoreboard compares each handshaken result against a sum-of-products model.
module tb_product_accumulator;

    localparam int WIDTH     = 4;
    localparam int ACC_WIDTH = 12;
    localparam int LEN_WIDTH = 5;
    localparam longint MODULUS = 64'd1 << ACC_WIDTH;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  p_valid;
    logic [2*WIDTH-1:0]    p;
    logic [ACC_WIDTH-1:0]  acc_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  overflow;

    product_accumulator #(
        .WIDTH(WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .len(len),
        .p_valid(p_valid),
        .p(p),
        .acc_out(acc_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] acc;
        logic                 ovf;
    } res_t;

    int     checks   = 0;
    int     failures = 0;
    res_t   exp_q[$];
    int     job_p[$];
    int     job_gap[$];
    logic [ACC_WIDTH-1:0] last_acc;
    logic                 last_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed output handshake consumes one expected result.
    always @(negedge clk) begin
        res_t e;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got acc=%0d expected no result", acc_out);
            end else begin
                e = exp_q.pop_front();
                check("result_acc", 32'(acc_out), 32'(e.acc));
                check("result_ovf", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    // Reference: the result is the true sum mod 2^ACC_WIDTH; overflow iff the true sum reaches 2^ACC_WIDTH.
    task automatic run_job(input int n, input int hold, input bit start_in_done);
        longint sum = 0;
        res_t   e;
        start = 1'b1;
        len   = LEN_WIDTH'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < job_gap[i]; g++) begin
                p_valid = 1'b0;
                p = 8'($urandom);
                @(posedge clk); #1;
            end
            check("no_early_valid", 32'(out_valid), 32'd0);
            p_valid = 1'b1;
            p = 8'(job_p[i]);
            sum += job_p[i];
            @(posedge clk); #1;
            p_valid = 1'b0;
        end
        check("result_latency", 32'(out_valid), 32'd1);
        e.acc = ACC_WIDTH'(sum % MODULUS);
        e.ovf = (sum >= MODULUS);
        exp_q.push_back(e);
        last_acc = e.acc;
        last_ovf = e.ovf;
        for (int h = 0; h < hold; h++) begin
            p_valid = 1'($urandom);
            p = 8'($urandom);
            start = start_in_done;
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_acc", 32'(acc_out), 32'(e.acc));
            check("hold_ovf", 32'(overflow), 32'(e.ovf));
        end
        p_valid = 1'b0;
        out_ready = 1'b1;
        start = start_in_done;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_busy", 32'(busy), 32'd0);
        check("post_hs_acc", 32'(acc_out), 32'(e.acc));
        check("post_hs_ovf", 32'(overflow), 32'(e.ovf));
    endtask

    task automatic stray_products(input int k);
        for (int i = 0; i < k; i++) begin
            p_valid = 1'b1;
            p = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
            check("stray_acc", 32'(acc_out), 32'(last_acc));
            check("stray_busy", 32'(busy), 32'd0);
        end
        p_valid = 1'b0;
    endtask

    task automatic fill_const(input int n, input int val);
        job_p.delete();
        job_gap.delete();
        for (int i = 0; i < n; i++) begin
            job_p.push_back(val);
            job_gap.push_back(0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; p_valid = 1'b0; p = '0; out_ready = 1'b0;
        last_acc = '0; last_ovf = 1'b0;
        #12;
        check("reset_acc", 32'(acc_out), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        fill_const(3, 225);
        run_job(3, 5, 1'b1);
        check("basic_ovf", 32'(last_ovf), 32'd0);

        job_p = '{10, 20};
        job_gap = '{0, 2};
        run_job(2, 0, 1'b0);

        job_p.delete(); job_gap.delete();
        run_job(0, 1, 1'b0);

        fill_const(19, 225);
        run_job(19, 2, 1'b0);
        fill_const(1, 5);
        run_job(1, 0, 1'b1);

        stray_products(3);

        // Abort a job mid-cycle, between clock edges.
        fill_const(3, 200);
        start = 1'b1; len = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_valid = 1'b1; p = 8'd200;
            @(posedge clk); #1;
        end
        p_valid = 1'b0;
        check("pre_abort_acc", 32'(acc_out), 32'd400);
        #2;
        reset = 1'b1;
        #1;
        check("abort_acc", 32'(acc_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        last_acc = '0; last_ovf = 1'b0;
        stray_products(2);
        fill_const(2, 7);
        run_job(2, 0, 1'b0);

        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(0, 31);
            job_p.delete(); job_gap.delete();
            for (int i = 0; i < n; i++) begin
                job_p.push_back($urandom_range(0, 255));
                job_gap.push_back($urandom_range(0, 2));
            end
            run_job(n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) stray_products(1);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
